// File: rtl/lpt_compat_tx_engine.sv
// Centronics compatibility-mode transmit engine: byte FIFO feeding a setup/strobe/hold/ack handshake.
// Optional WAIT_ACK timeout is built in when the macro LPT_TIMEOUT_EN is defined.
module lpt_compat_tx_engine #(
   parameter int unsigned FIFO_AW     = 4,
   parameter int unsigned SETUP_CYC   = 33,
   parameter int unsigned STROBE_CYC  = 33,
   parameter int unsigned HOLD_CYC    = 33,
   parameter int unsigned TIMEOUT_CYC = 330000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   input  logic               BUSY,
   input  logic               ACK,
   output logic [7:0]         lpt_data,
   output logic               STROBE,
   output logic               fifo_empty,
   output logic               fifo_full,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               tx_active,
   output logic               byte_done,
   output logic               timeout_err
);

   localparam int unsigned DEPTH   = 2 ** FIFO_AW;
   localparam int unsigned PTR_W   = FIFO_AW + 1;
   localparam int unsigned MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAX_B   = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STB,
      S_HOLD,
      S_WAIT_ACK
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   level_q, level_d;
   logic               empty_q, empty_d;
   logic               full_q, full_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         data_q, data_d;
   logic               strobe_q, strobe_d;
   logic               active_q, active_d;
   logic               done_q, done_d;
   logic               terr_q, terr_d;
   logic               busy_meta_q, busy_meta_d;
   logic               busy_s_q, busy_s_d;
   logic               ack_meta_q, ack_meta_d;
   logic               ack_s_q, ack_s_d;
   logic               ack_prev_q, ack_prev_d;
   logic               busy_seen_q, busy_seen_d;
   logic               ack_seen_q, ack_seen_d;
   logic               push_c, pop_c, ack_fall_c;
   logic [7:0]         mem_q [DEPTH];

   // FIFO storage; contents need no reset since pointers gate every read
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
   end

   always_comb begin
      busy_meta_d = BUSY;
      busy_s_d    = busy_meta_q;
      ack_meta_d  = ACK;
      ack_s_d     = ack_meta_q;
      ack_prev_d  = ack_s_q;
      ack_fall_c  = ack_prev_q & ~ack_s_q;

      push_c      = wr_en & ~full_q;
      pop_c       = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      strobe_d    = strobe_q;
      done_d      = 1'b0;
      terr_d      = terr_q;
      busy_seen_d = busy_seen_q;
      ack_seen_d  = ack_seen_q;
      overflow_d  = overflow_q | (wr_en & full_q);

      case (state_q)
         S_IDLE: begin
            if (!empty_q && !busy_s_q) begin
               pop_c   = 1'b1;
               data_d  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
               state_d = S_SETUP;
               cnt_d   = '0;
            end
         end
         S_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
               strobe_d = 1'b0;
               state_d  = S_STB;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STB: begin
            if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
               strobe_d   = 1'b1;
               state_d    = S_HOLD;
               cnt_d      = '0;
               ack_seen_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            // A fast printer may pulse nACK while data is still held; remember it
            ack_seen_d = ack_seen_q | ack_fall_c;
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               state_d     = S_WAIT_ACK;
               cnt_d       = '0;
               busy_seen_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_ACK: begin
            busy_seen_d = busy_seen_q | busy_s_q;
            ack_seen_d  = ack_seen_q | ack_fall_c;
            if (ack_seen_q || ack_fall_c || (busy_seen_q && !busy_s_q)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
`ifdef LPT_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               terr_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            else begin
               cnt_d = '0;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
      level_d  = wr_ptr_d - rd_ptr_d;
      empty_d  = (level_d == '0);
      full_d   = (level_d == PTR_W'(DEPTH));
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         data_q      <= 8'h00;
         strobe_q    <= 1'b1;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         terr_q      <= 1'b0;
         busy_meta_q <= 1'b0;
         busy_s_q    <= 1'b0;
         ack_meta_q  <= 1'b1;
         ack_s_q     <= 1'b1;
         ack_prev_q  <= 1'b1;
         busy_seen_q <= 1'b0;
         ack_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         data_q      <= data_d;
         strobe_q    <= strobe_d;
         active_q    <= active_d;
         done_q      <= done_d;
         terr_q      <= terr_d;
         busy_meta_q <= busy_meta_d;
         busy_s_q    <= busy_s_d;
         ack_meta_q  <= ack_meta_d;
         ack_s_q     <= ack_s_d;
         ack_prev_q  <= ack_prev_d;
         busy_seen_q <= busy_seen_d;
         ack_seen_q  <= ack_seen_d;
      end
   end

   assign lpt_data    = data_q;
   assign STROBE      = strobe_q;
   assign fifo_empty  = empty_q;
   assign fifo_full   = full_q;
   assign fifo_level  = level_q;
   assign overflow    = overflow_q;
   assign tx_active   = active_q;
   assign byte_done   = done_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_lpt_compat_tx_engine.sv
// Directed bench for lpt_compat_tx_engine: reset, handshake timing, FIFO, push/pop overlap, BUSY handshake, timeout.
module tb_lpt_compat_tx_engine;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       BUSY;
   logic       ACK;
   logic [7:0] lpt_data;
   logic       STROBE;
   logic       fifo_empty;
   logic       fifo_full;
   logic [4:0] fifo_level;
   logic       overflow;
   logic       tx_active;
   logic       byte_done;
   logic       timeout_err;

   int total;
   int bad;

   lpt_compat_tx_engine #(
      .FIFO_AW     (4),
      .SETUP_CYC   (33),
      .STROBE_CYC  (33),
      .HOLD_CYC    (33),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .BUSY        (BUSY),
      .ACK         (ACK),
      .lpt_data    (lpt_data),
      .STROBE      (STROBE),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .tx_active   (tx_active),
      .byte_done   (byte_done),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic wait_strobe(input logic lvl, input int limit, output bit ok);
      int n;
      n = 0;
      while (STROBE !== lvl && n < limit) begin
         tick();
         n++;
      end
      ok = (STROBE === lvl);
   endtask

   // Printer model: capture data while strobed, pulse nACK 5 cycles after strobe rises
   task automatic printer_cycle(output logic [7:0] b, output bit ok);
      bit ok1, ok2;
      int n;
      b = 8'hxx;
      wait_strobe(1'b0, 300, ok1);
      b = lpt_data;
      wait_strobe(1'b1, 100, ok2);
      repeat (5) tick();
      ACK = 1'b0;
      repeat (3) tick();
      ACK = 1'b1;
      n = 0;
      while (byte_done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      ok = ok1 && ok2 && (byte_done === 1'b1);
   endtask

   task automatic test_reset();
      BUSY = 1'b0;
      ACK  = 1'b1;
      do_reset();
      total++; if (STROBE !== 1'b1) begin bad++; $display("FAIL reset_strobe got=%b exp=1", STROBE); end
      total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", tx_active); end
      total++; if (lpt_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", lpt_data); end
      total++; if ({fifo_full, overflow, byte_done, timeout_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b exp=0000", {fifo_full, overflow, byte_done, timeout_err});
      end
   endtask

   task automatic test_single_byte();
      int n;
      int dones;
      BUSY = 1'b0;
      ACK  = 1'b1;
      do_reset();
      push_byte(8'hA5);
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
      tick();
      total++; if (lpt_data !== 8'hA5 || tx_active !== 1'b1) begin
         bad++; $display("FAIL single_pop got=%h/%b exp=a5/1", lpt_data, tx_active);
      end
      n = 0;
      while (STROBE === 1'b1 && n < 100) begin tick(); n++; end
      total++; if (n != 33 || lpt_data !== 8'hA5) begin
         bad++; $display("FAIL single_setup got=%0d/%h exp=33/a5", n, lpt_data);
      end
      n = 0;
      while (STROBE === 1'b0 && n < 100) begin tick(); n++; end
      total++; if (n != 33) begin bad++; $display("FAIL single_strobe_width got=%0d exp=33", n); end
      repeat (5) tick();
      ACK = 1'b0;
      repeat (3) tick();
      ACK = 1'b1;
      dones = 0;
      repeat (100) begin tick(); if (byte_done === 1'b1) dones++; end
      total++; if (dones != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", dones); end
      total++; if (tx_active !== 1'b0 || lpt_data !== 8'hA5 || fifo_empty !== 1'b1) begin
         bad++; $display("FAIL single_idle got=%b/%h/%b exp=0/a5/1", tx_active, lpt_data, fifo_empty);
      end
   endtask

   task automatic test_fifo_overflow();
      logic [7:0] b;
      bit ok;
      BUSY = 1'b1;
      ACK  = 1'b1;
      do_reset();
      repeat (3) tick();
      for (int i = 0; i < 17; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
      tick();
      total++; if (fifo_level !== 5'd16 || fifo_full !== 1'b1) begin
         bad++; $display("FAIL fifo_full got=%0d/%b exp=16/1", fifo_level, fifo_full);
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fifo_overflow got=%b exp=1", overflow); end
      total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL fifo_busy_hold got=%b exp=0", tx_active); end
      BUSY = 1'b0;
      for (int i = 0; i < 16; i++) begin
         printer_cycle(b, ok);
         total++; if (!ok || b !== 8'(i)) begin
            bad++; $display("FAIL fifo_order[%0d] got=%h ok=%0d exp=%h", i, b, ok, 8'(i));
         end
      end
      repeat (150) tick();
      total++; if (fifo_empty !== 1'b1 || fifo_level !== 5'd0 || tx_active !== 1'b0) begin
         bad++; $display("FAIL fifo_drained got=%b/%0d/%b exp=1/0/0", fifo_empty, fifo_level, tx_active);
      end
   endtask

   task automatic test_simul_push_pop();
      logic [7:0] b;
      bit ok;
      BUSY = 1'b1;
      ACK  = 1'b1;
      do_reset();
      repeat (3) tick();
      push_byte(8'h30);
      push_byte(8'h31);
      push_byte(8'h32);
      total++; if (fifo_level !== 5'd3) begin bad++; $display("FAIL simul_pre_level got=%0d exp=3", fifo_level); end
      BUSY = 1'b0;
      tick();
      tick();
      wr_en   = 1'b1;
      wr_data = 8'h33;
      tick();
      wr_en = 1'b0;
      total++; if (fifo_level !== 5'd3 || tx_active !== 1'b1 || lpt_data !== 8'h30) begin
         bad++; $display("FAIL simul_level got=%0d/%b/%h exp=3/1/30", fifo_level, tx_active, lpt_data);
      end
      for (int i = 0; i < 4; i++) begin
         printer_cycle(b, ok);
         total++; if (!ok || b !== 8'(8'h30 + i)) begin
            bad++; $display("FAIL simul_order[%0d] got=%h ok=%0d exp=%h", i, b, ok, 8'(8'h30 + i));
         end
      end
      repeat (150) tick();
      total++; if (fifo_empty !== 1'b1 || tx_active !== 1'b0) begin
         bad++; $display("FAIL simul_drained got=%b/%b exp=1/0", fifo_empty, tx_active);
      end
   endtask

   task automatic test_busy_handshake();
      bit ok1, ok2;
      int n;
      int early;
      BUSY = 1'b0;
      ACK  = 1'b1;
      do_reset();
      push_byte(8'h5A);
      wait_strobe(1'b0, 200, ok1);
      wait_strobe(1'b1, 100, ok2);
      total++; if (!ok1 || !ok2) begin bad++; $display("FAIL busy_strobe ok=%0d%0d exp=11", ok1, ok2); end
      repeat (10) tick();
      BUSY = 1'b1;
      early = 0;
      repeat (40) begin tick(); if (byte_done === 1'b1) early++; end
      BUSY = 1'b0;
      total++; if (early != 0 || tx_active !== 1'b1) begin
         bad++; $display("FAIL busy_early got=%0d/%b exp=0/1", early, tx_active);
      end
      n = 0;
      while (byte_done !== 1'b1 && n < 20) begin tick(); n++; end
      total++; if (n < 2 || n > 3) begin bad++; $display("FAIL busy_done_delay got=%0d exp=2..3", n); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      BUSY = 1'b0;
      ACK  = 1'b1;
      do_reset();
      push_byte(8'h11);
      push_byte(8'h12);
      push_byte(8'h13);
      wait_strobe(1'b0, 200, ok);
      total++; if (!ok || fifo_level !== 5'd2) begin
         bad++; $display("FAIL mid_pre got=%0d/%0d exp=1/2", ok, fifo_level);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (STROBE !== 1'b1 || fifo_level !== 5'd0 || fifo_empty !== 1'b1 || tx_active !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%b/%0d/%b/%b exp=1/0/1/0", STROBE, fifo_level, fifo_empty, tx_active);
      end
   endtask

   task automatic test_timeout();
      bit ok1, ok2;
      int dones;
      BUSY = 1'b0;
      ACK  = 1'b1;
      do_reset();
      push_byte(8'h77);
      push_byte(8'h78);
      wait_strobe(1'b0, 200, ok1);
      wait_strobe(1'b1, 100, ok2);
      total++; if (!ok1 || !ok2) begin bad++; $display("FAIL tmo_strobe ok=%0d%0d exp=11", ok1, ok2); end
      repeat (33) tick();
      dones = 0;
`ifdef LPT_TIMEOUT_EN
      repeat (99) begin tick(); if (byte_done === 1'b1) dones++; end
      total++; if (timeout_err !== 1'b0 || tx_active !== 1'b1) begin
         bad++; $display("FAIL tmo_before got=%b/%b exp=0/1", timeout_err, tx_active);
      end
      tick();
      if (byte_done === 1'b1) dones++;
      total++; if (timeout_err !== 1'b1 || tx_active !== 1'b0) begin
         bad++; $display("FAIL tmo_at got=%b/%b exp=1/0", timeout_err, tx_active);
      end
      total++; if (dones != 0) begin bad++; $display("FAIL tmo_no_done got=%0d exp=0", dones); end
      tick();
      total++; if (tx_active !== 1'b1 || lpt_data !== 8'h78) begin
         bad++; $display("FAIL tmo_next got=%b/%h exp=1/78", tx_active, lpt_data);
      end
`else
      repeat (200) begin tick(); if (byte_done === 1'b1) dones++; end
      total++; if (tx_active !== 1'b1 || timeout_err !== 1'b0 || dones != 0) begin
         bad++; $display("FAIL tmo_stuck got=%b/%b/%0d exp=1/0/0", tx_active, timeout_err, dones);
      end
`endif
      do_reset();
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      BUSY    = 1'b0;
      ACK     = 1'b1;
      test_reset();
      test_single_byte();
      test_fifo_overflow();
      test_simul_push_pop();
      test_busy_handshake();
      test_reset_mid();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
